waves_nios_nios2_qsys_0_oci_dct_packer: RTL and testbench

Direct-call-trace (DCT) packer for the Nios II OCI instruction-trace path. It collects 2-bit branch-outcome codes into a 30-bit shift buffer and drives the live `dct_buffer`/`dct_count` registers consumed by the OCI test bench. It emits full or flushed buffers, plus indirect-target address frames, as trace-message (ITM) frames over a valid/ready handshake to the trace FIFO downstream.

---
 rtl/waves_nios_oci_pkg.sv | 22 ++
 rtl/waves_nios_nios2_qsys_0_oci_dct_packer.sv | 137 +++++++++++++
 tb/tb_waves_nios_nios2_qsys_0_oci_dct_packer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/waves_nios_oci_pkg.sv
// Shared constants and types for the Nios II OCI direct-call-trace packer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package waves_nios_oci_pkg;

    // ITM frame type nibble
    localparam logic [3:0] ITM_T_DCT  = 4'h1;
    localparam logic [3:0] ITM_T_ADDR = 4'h2;

    // Branch-outcome codes; RSVD is dropped on input and never counted
    localparam logic [1:0] DCT_RSVD      = 2'b00;
    localparam logic [1:0] DCT_TAKEN     = 2'b01;
    localparam logic [1:0] DCT_NOT_TAKEN = 2'b10;
    localparam logic [1:0] DCT_CALL      = 2'b11;

    // COLLECT: codes/flushes accepted; HOLD_ADDR: address frame waits in addr_q
    typedef enum logic {
        COLLECT   = 1'b0,
        HOLD_ADDR = 1'b1
    } dct_state_e;

endpackage

// File: rtl/waves_nios_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit branch-outcome codes into 30-bit DCT frames, plus address frames on flush.
// Latency: 1 cycle from accept edge to itm_valid; address frame follows a partial DCT frame.
// Backpressure: itm held while itm_valid & !itm_ready; in_ready drops until the output slot frees.
// Optional: WAVES_NIOS_OCI_DCT_FRAME_CNT_EN adds a saturating 16-bit consumed-frame counter.
module waves_nios_nios2_qsys_0_oci_dct_packer
    import waves_nios_oci_pkg::*;
#(
    parameter int DCT_CODES = 15,
    parameter int ITM_W     = 38
) (
    input  logic                   clk,
    input  logic                   jrst_n,
    input  logic                   trc_on,
    input  logic                   dct_valid,
    input  logic [1:0]             dct_code,
    input  logic                   flush_valid,
    input  logic [31:0]            flush_addr,
    output logic                   in_ready,
    output logic [2*DCT_CODES-1:0] dct_buffer,
    output logic [3:0]             dct_count,
    output logic [ITM_W-1:0]       itm,
    output logic                   itm_valid,
    input  logic                   itm_ready
`ifdef WAVES_NIOS_OCI_DCT_FRAME_CNT_EN
    ,
    output logic [15:0]            frame_cnt
`endif
);

    localparam int         BUF_W    = 2 * DCT_CODES;
    localparam logic [3:0] FULL_CNT = 4'(DCT_CODES);

    dct_state_e       state_q, state_n;
    logic [31:0]      addr_q, addr_n;
    logic [BUF_W-1:0] buf_n;
    logic [3:0]       cnt_n;
    logic [ITM_W-1:0] itm_n;
    logic             itm_valid_n;

    logic             out_free;
    logic             code_acc;
    logic             flush_acc;
    logic [BUF_W-1:0] app_buf;
    logic [3:0]       app_cnt;

    // Output slot is free when empty or being drained this cycle
    assign out_free  = !itm_valid || itm_ready;
    assign in_ready  = trc_on && (state_q == COLLECT) && out_free;
    assign code_acc  = dct_valid && in_ready && (dct_code != DCT_RSVD);
    assign flush_acc = flush_valid && in_ready;

    // Buffer/count as they stand after appending any code accepted this cycle
    assign app_buf = code_acc ? {dct_buffer[BUF_W-3:0], dct_code} : dct_buffer;
    assign app_cnt = code_acc ? (dct_count + 4'd1) : dct_count;

    // Next-state, buffer and frame-register selection
    always_comb begin
        state_n     = state_q;
        addr_n      = addr_q;
        buf_n       = dct_buffer;
        cnt_n       = dct_count;
        itm_n       = itm;
        itm_valid_n = itm_valid && !itm_ready;

        unique case (state_q)
            COLLECT: begin
                if (flush_acc) begin
                    if (app_cnt == 4'd0) begin
                        // Nothing buffered: the address frame goes straight out
                        itm_n       = ITM_W'({ITM_T_ADDR, 2'b00, flush_addr});
                        itm_valid_n = 1'b1;
                    end else begin
                        // Partial buffer goes first; address waits for the slot
                        itm_n       = ITM_W'({ITM_T_DCT, app_cnt, app_buf});
                        itm_valid_n = 1'b1;
                        buf_n       = '0;
                        cnt_n       = 4'd0;
                        addr_n      = flush_addr;
                        state_n     = HOLD_ADDR;
                    end
                end else if (code_acc) begin
                    if (app_cnt == FULL_CNT) begin
                        // Full buffer ships and clears on the same edge, no bubble
                        itm_n       = ITM_W'({ITM_T_DCT, app_cnt, app_buf});
                        itm_valid_n = 1'b1;
                        buf_n       = '0;
                        cnt_n       = 4'd0;
                    end else begin
                        buf_n = app_buf;
                        cnt_n = app_cnt;
                    end
                end
            end
            HOLD_ADDR: begin
                if (out_free) begin
                    itm_n       = ITM_W'({ITM_T_ADDR, 2'b00, addr_q});
                    itm_valid_n = 1'b1;
                    state_n     = COLLECT;
                end
            end
            default: begin
                state_n = COLLECT;
            end
        endcase
    end

    // State, buffer and frame registers; reset discards everything in flight
    always_ff @(posedge clk or negedge jrst_n) begin
        if (!jrst_n) begin
            state_q    <= COLLECT;
            addr_q     <= 32'd0;
            dct_buffer <= '0;
            dct_count  <= 4'd0;
            itm        <= '0;
            itm_valid  <= 1'b0;
        end else begin
            state_q    <= state_n;
            addr_q     <= addr_n;
            dct_buffer <= buf_n;
            dct_count  <= cnt_n;
            itm        <= itm_n;
            itm_valid  <= itm_valid_n;
        end
    end

`ifdef WAVES_NIOS_OCI_DCT_FRAME_CNT_EN
    // Count consumed frames, sticking at all-ones
    always_ff @(posedge clk or negedge jrst_n) begin
        if (!jrst_n) begin
            frame_cnt <= 16'd0;
        end else if (itm_valid && itm_ready && (frame_cnt != 16'hFFFF)) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_waves_nios_nios2_qsys_0_oci_dct_packer.sv
// Scoreboard bench for the DCT packer with a list-based reference model.
// Latency: n/a (testbench).
// Backpressure: randomised itm_ready.
module tb_waves_nios_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        jrst_n = 1'b0;
    logic        trc_on = 1'b0;
    logic        dct_valid = 1'b0;
    logic [1:0]  dct_code = 2'b00;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_addr = 32'd0;
    logic        in_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [37:0] itm;
    logic        itm_valid;
    logic        itm_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: codes currently buffered (oldest first) and frames owed downstream
    int          codes[$];
    logic [37:0] sb[$];

    waves_nios_nios2_qsys_0_oci_dct_packer dut (
        .clk         (clk),
        .jrst_n      (jrst_n),
        .trc_on      (trc_on),
        .dct_valid   (dct_valid),
        .dct_code    (dct_code),
        .flush_valid (flush_valid),
        .flush_addr  (flush_addr),
        .in_ready    (in_ready),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
        .itm         (itm),
        .itm_valid   (itm_valid),
        .itm_ready   (itm_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Buffered codes as a number, newest code in the low two bits
    function automatic logic [29:0] model_buf();
        logic [29:0] b;
        b = '0;
        foreach (codes[i]) b = (b << 2) | 30'(codes[i]);
        return b;
    endfunction

    function automatic logic [37:0] dct_frame();
        logic [3:0] n;
        n = 4'(codes.size());
        return {4'h1, n, model_buf()};
    endfunction

    // Apply one accepted input cycle to the model
    task automatic model_accept(input bit dv, input logic [1:0] c, input bit fv, input logic [31:0] a);
        if (dv && c != 2'b00) codes.push_back(int'(c));
        if (fv) begin
            if (codes.size() != 0) begin
                sb.push_back(dct_frame());
                codes.delete();
            end
            sb.push_back({4'h2, 2'b00, a});
        end else if (codes.size() == 15) begin
            sb.push_back(dct_frame());
            codes.delete();
        end
    endtask

    // One clock of stimulus; frames owed downstream determine whether input may be taken
    task automatic step(input bit t, input bit dv, input logic [1:0] c, input bit fv,
                        input logic [31:0] a, input bit r);
        bit exp_rdy;
        @(posedge clk);
        #2;
        trc_on = t; dct_valid = dv; dct_code = c; flush_valid = fv; flush_addr = a; itm_ready = r;
        #1;
        vectors++;
        chk("dct_count", 64'(dct_count), 64'(codes.size()));
        chk("dct_buffer", 64'(dct_buffer), 64'(model_buf()));
        exp_rdy = t && (sb.size() == 0 || (sb.size() == 1 && r));
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (exp_rdy) model_accept(dv, c, fv, a);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00, 1'b0, 32'd0, r);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        jrst_n = 1'b0;
        dct_valid = 1'b0; flush_valid = 1'b0; itm_ready = 1'b0;
        #1;
        chk("rst_itm_valid", 64'(itm_valid), 64'd0);
        chk("rst_dct_count", 64'(dct_count), 64'd0);
        chk("rst_itm", 64'(itm), 64'd0);
        sb.delete();
        codes.delete();
        repeat (2) @(posedge clk);
        #2;
        jrst_n = 1'b1;
    endtask

    // Monitor: the presented frame must match the oldest owed frame for as long as it is shown
    always @(negedge clk) begin
        if (jrst_n && itm_valid) begin
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_frame: got %0h expected no frame at %0t", itm, $time);
            end else begin
                chk("itm_frame", 64'(itm), 64'(sb[0]));
                if (itm_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [1:0] rc;
        int         wait_cnt;

        do_reset();
        trc_on = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // 15 taken codes fill the buffer and ship as one frame
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 2'b01, 1'b0, 32'd0, 1'b1);
        idle(1, 1'b1);
        chk("full_frame", 64'(itm), 64'({4'h1, 4'd15, 30'h1555_5555}));
        chk("full_count_zero", 64'(dct_count), 64'd0);
        idle(2, 1'b1);

        // Three codes then a flush: partial DCT frame, then address frame
        step(1'b1, 1'b1, 2'b01, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 2'b10, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 2'b11, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1000, 1'b1);
        idle(1, 1'b1);
        chk("partial_frame", 64'(itm), 64'({4'h1, 4'd3, 30'h1B}));
        idle(1, 1'b1);
        chk("addr_frame", 64'(itm), 64'({4'h2, 2'b00, 32'h0000_1000}));
        idle(2, 1'b1);

        // Flush with nothing buffered: address frame only
        step(1'b1, 1'b0, 2'b00, 1'b1, 32'hDEAD_BEEF, 1'b1);
        idle(3, 1'b1);

        // Frame pending with downstream stalled for five cycles
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 2'b10, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'b11, 1'b0, 32'd0, 1'b0);
        idle(3, 1'b1);

        // Count 14, then a call code together with a flush
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 2'($urandom_range(1, 3)), 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 2'b11, 1'b1, 32'h0BAD_F00D, 1'b1);
        idle(4, 1'b1);

        // Reset while the address frame is held back
        step(1'b1, 1'b1, 2'b01, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 2'b10, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b1, 32'h1234_5678, 1'b0);
        idle(1, 1'b0);
        do_reset();
        idle(6, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rc = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), rc,
                 ($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 9) < 7));
        end

        // Drain owed frames within a bounded number of cycles
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 50) begin
            step(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 1'b1);
            wait_cnt++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
